dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/arb_sat_counter.sv | 23 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the DMEM arbiter: FSM state, owner encoding and a counter-width helper.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE,
    D_LOCKED
  } arbState_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P,
    OWN_D
  } owner_e;

  // Bits needed to hold the values 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline port, debug port and DMEM port seen by the arbiter.
interface dmem_arbiter_if;
  logic        p_req;
  logic        p_we;
  logic [2:0]  p_funct3;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_stall;
  logic [31:0] p_rdata;

  logic        d_req;
  logic        d_we;
  logic        d_lock;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;

  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  p_req, p_we, p_funct3, p_addr, p_wdata,
    input  d_req, d_we, d_lock, d_funct3, d_addr, d_wdata,
    input  mem_rdata,
    output p_stall, p_rdata, d_gnt, d_rdata,
    output mem_we, mem_funct3, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output p_req, p_we, p_funct3, p_addr, p_wdata,
    output d_req, d_we, d_lock, d_funct3, d_addr, d_wdata,
    output mem_rdata,
    input  p_stall, p_rdata, d_gnt, d_rdata,
    input  mem_we, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Zero-latency DMEM arbiter between the pipeline memory stage (P) and a debug/loader port (D),
// with P priority, starvation relief for D, and a bounded D lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  localparam int STARVE_W = cntWidth(STARVE_LIMIT);
  localparam int LOCK_W   = cntWidth(LOCK_MAX);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(LOCK_MAX - 1);

  arbState_e           state;
  arbState_e           stateNext;
  owner_e              owner;
  logic [STARVE_W-1:0] starveCnt;
  logic [LOCK_W-1:0]   lockCnt;
  logic                rearm;
  logic                starveHit;
  logic                lockHit;
  logic                starveInc;
  logic                starveClr;
  logic                lockInc;
  logic                lockClr;

  assign starveHit = bus.d_req && (starveCnt == STARVE_TOP);

  // Ownership; nobody owns DMEM while reset is held so no stray write can occur.
  always_comb begin
    owner = OWN_NONE;
    if (!reset_n) begin
      owner = OWN_NONE;
    end else if (state == D_LOCKED) begin
      owner = bus.d_req ? OWN_D : OWN_NONE;
    end else if (starveHit) begin
      owner = OWN_D;
    end else if (bus.p_req) begin
      owner = OWN_P;
    end else if (bus.d_req) begin
      owner = OWN_D;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    stateNext = state;
    lockHit   = 1'b0;
    case (state)
      IDLE: begin
        if (owner == OWN_D && bus.d_lock && rearm) stateNext = D_LOCKED;
      end
      D_LOCKED: begin
        lockHit = (owner == OWN_D) && bus.d_lock && (lockCnt >= LOCK_LAST);
        if (!bus.d_lock || !bus.d_req || lockHit) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign starveInc = (owner == OWN_P) && bus.d_req;
  assign starveClr = (owner == OWN_D) || !bus.d_req;
  assign lockInc   = (owner == OWN_D) && bus.d_lock;
  assign lockClr   = (stateNext == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rearm <= 1'b1;
    end else begin
      state <= stateNext;
      // A forced release must see d_lock drop before another lock is allowed.
      if (lockHit) begin
        rearm <= 1'b0;
      end else if (!bus.d_lock) begin
        rearm <= 1'b1;
      end
    end
  end

  arb_sat_counter #(.WIDTH(STARVE_W)) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (starveInc),
    .clr     (starveClr),
    .cnt     (starveCnt)
  );

  arb_sat_counter #(.WIDTH(LOCK_W)) u_lock_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (lockInc),
    .clr     (lockClr),
    .cnt     (lockCnt)
  );

  always_comb begin
    bus.mem_we     = 1'b0;
    bus.mem_funct3 = 3'd0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.p_rdata    = 32'd0;
    bus.d_rdata    = 32'd0;
    case (owner)
      OWN_P: begin
        bus.mem_we     = bus.p_we;
        bus.mem_funct3 = bus.p_funct3;
        bus.mem_addr   = bus.p_addr;
        bus.mem_wdata  = bus.p_wdata;
        bus.p_rdata    = bus.mem_rdata;
      end
      OWN_D: begin
        bus.mem_we     = bus.d_we;
        bus.mem_funct3 = bus.d_funct3;
        bus.mem_addr   = bus.d_addr;
        bus.mem_wdata  = bus.d_wdata;
        bus.d_rdata    = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.p_stall = bus.p_req && (owner != OWN_P);
  assign bus.d_gnt   = bus.d_req && (owner == OWN_D);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: idle, single-port access, contention, lock and reset-in-lock.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errCnt = 0;
  int   checkCnt = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Word-addressed DMEM model: combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic pReq, input logic pWe, input logic dReq,
                       input logic dWe, input logic dLock);
    bus.p_req  = pReq;
    bus.p_we   = pWe;
    bus.d_req  = dReq;
    bus.d_we   = dWe;
    bus.d_lock = dLock;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'hA5A5_0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.p_funct3 = 3'd2;
    bus.p_addr   = 32'h0;
    bus.p_wdata  = 32'h0;
    bus.d_funct3 = 3'd1;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;

    // In reset a P store must not reach DMEM.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.p_addr = 32'h10;
    @(negedge clk);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    nextCycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.p_addr = 32'h0;
    reset_n = 1'b1;

    // Idle: bus quiet, read data gated even though mem[0] is non-zero.
    @(negedge clk);
    check("idle_mem_we",   32'(bus.mem_we), 32'd0);
    check("idle_mem_addr", bus.mem_addr, 32'd0);
    check("idle_mem_wdat", bus.mem_wdata, 32'd0);
    check("idle_p_rdata",  bus.p_rdata, 32'd0);
    check("idle_d_rdata",  bus.d_rdata, 32'd0);
    check("idle_p_stall",  32'(bus.p_stall), 32'd0);
    check("idle_d_gnt",    32'(bus.d_gnt), 32'd0);
    nextCycle();

    // P store then P load.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.p_addr  = 32'h10;
    bus.p_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("pst_mem_we",   32'(bus.mem_we), 32'd1);
    check("pst_mem_addr", bus.mem_addr, 32'h10);
    check("pst_mem_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
    check("pst_funct3",   32'(bus.mem_funct3), 32'd2);
    check("pst_p_stall",  32'(bus.p_stall), 32'd0);
    nextCycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pld_p_rdata", bus.p_rdata, 32'hDEAD_BEEF);
    check("pld_mem_we",  32'(bus.mem_we), 32'd0);
    check("pld_d_rdata", bus.d_rdata, 32'd0);
    nextCycle();

    // D store then D load with P idle.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("dst_d_gnt",    32'(bus.d_gnt), 32'd1);
    check("dst_mem_addr", bus.mem_addr, 32'h20);
    check("dst_funct3",   32'(bus.mem_funct3), 32'd1);
    check("dst_p_stall",  32'(bus.p_stall), 32'd0);
    nextCycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("dld_d_rdata", bus.d_rdata, 32'h1234_5678);
    check("dld_p_rdata", bus.p_rdata, 32'd0);
    nextCycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // Contention without lock: P,P,P,P,D repeating.
    bus.p_addr = 32'h40;
    bus.d_addr = 32'h80;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic dTurn;
      dTurn = ((i % 5) == 4);
      @(negedge clk);
      check($sformatf("cont%0d_p_stall", i), 32'(bus.p_stall), 32'(dTurn));
      check($sformatf("cont%0d_d_gnt", i),   32'(bus.d_gnt),   32'(dTurn));
      check($sformatf("cont%0d_addr", i),    bus.mem_addr, dTurn ? 32'h80 : 32'h40);
      nextCycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // Lock: 4 P grants, then 16 locked D cycles, then no re-lock until d_lock drops.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 26; i++) begin
      logic dTurn;
      dTurn = ((i >= 4) && (i <= 19)) || (i == 24);
      @(negedge clk);
      check($sformatf("lock%0d_d_gnt", i),   32'(bus.d_gnt),   32'(dTurn));
      check($sformatf("lock%0d_p_stall", i), 32'(bus.p_stall), 32'(dTurn));
      nextCycle();
    end

    // d_lock low for one cycle re-arms; a new lock then stalls P.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    bus.d_wdata = 32'hCAFE_0001;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("relock1_d_gnt", 32'(bus.d_gnt), 32'd1);
    nextCycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("relock%0d_p_stall", i), 32'(bus.p_stall), 32'd1);
      check($sformatf("relock%0d_mem_we", i),  32'(bus.mem_we),  32'd1);
      nextCycle();
    end

    // Reset during lock cycle 5 kills the write at once.
    check("rstlock_pre_we", 32'(bus.mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstlock_mem_we", 32'(bus.mem_we), 32'd0);
    check("rstlock_d_gnt",  32'(bus.d_gnt),  32'd0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_p_stall", 32'(bus.p_stall), 32'd0);
    check("postrst_d_gnt",   32'(bus.d_gnt),   32'd0);
    check("postrst_addr",    bus.mem_addr, 32'h40);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
